// File: rtl/sobel_pkg.sv
// sobel_pkg
// Shared definitions for the Sobel gradient engine:
//   - state_e   : controller state encoding (exposed on the debug port)
//   - GRAD_W    : width of the signed Gx/Gy gradients (+/-1020)
//   - MAG_W     : width of the unsigned |Gx|+|Gy| sum (max 2040)
//   - SAT_LIMIT : value the output pixel saturates to
//   - abs_grad  : magnitude of a signed gradient, zero-extended to MAG_W
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RD,
    ST_LAST,
    ST_CALC,
    ST_WR,
    ST_DONE
  } state_e;

  localparam int GRAD_W    = 11;
  localparam int MAG_W     = 12;
  localparam int SAT_LIMIT = 255;
  localparam int NUM_TAPS  = 9;

  // Gradients never reach -1024, so the two's-complement negation below
  // cannot overflow and the result is always a true magnitude.
  function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    logic [GRAD_W-1:0] u;
    u = g[GRAD_W-1] ? (~g + 1'b1) : g;
    return MAG_W'(u);
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// sobel_kernel
// Combinational 3x3 Sobel operator. Taps are numbered p[r*3+c] with r the
// row (top to bottom) and c the column (left to right). Produces the
// clamped gradient magnitude min(|Gx|+|Gy|, SAT_LIMIT).
// Ports:
//   taps_i : nine neighbourhood pixels, tap k in taps_i[k]
//   pix_o  : clamped magnitude
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] taps_i,
  output logic [DATA_WIDTH-1:0]               pix_o
);

  logic [GRAD_W-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [GRAD_W-1:0] gx, gy;
  logic [MAG_W-1:0]         mag;

  function automatic logic [GRAD_W-1:0] ext(input logic [DATA_WIDTH-1:0] p);
    return GRAD_W'(p);
  endfunction

  // Each weighted half-sum is at most 4*255 = 1020, so it fits unsigned in
  // GRAD_W-1 bits and the difference is a valid signed GRAD_W value.
  always_comb begin
    gx_pos = ext(taps_i[2]) + (ext(taps_i[5]) << 1) + ext(taps_i[8]);
    gx_neg = ext(taps_i[0]) + (ext(taps_i[3]) << 1) + ext(taps_i[6]);
    gy_pos = ext(taps_i[6]) + (ext(taps_i[7]) << 1) + ext(taps_i[8]);
    gy_neg = ext(taps_i[0]) + (ext(taps_i[1]) << 1) + ext(taps_i[2]);
    gx     = signed'(gx_pos - gx_neg);
    gy     = signed'(gy_pos - gy_neg);
    mag    = abs_grad(gx) + abs_grad(gy);
    pix_o  = (mag > MAG_W'(SAT_LIMIT)) ? DATA_WIDTH'(SAT_LIMIT) : mag[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/sobel_core.sv
// sobel_core
// Frame-level Sobel engine. On start it walks the frame in raster order:
// border pixels are written as 0 without reading the source; interior
// pixels read their 3x3 neighbourhood one tap per cycle, run the kernel
// and write the clamped magnitude.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start            : one-cycle frame request, honoured only in IDLE
//   busy, done       : frame in progress / one-cycle completion pulse
//   src_addr, src_ce : source RAM read port (1-cycle latency)
//   src_q            : source read data
//   dst_addr, dst_ce, dst_we, dst_d : result RAM write port
//   state_dbg        : current controller state
// Handshake: src_q is sampled the cycle after src_ce was high; a result
// write happens in every cycle where dst_ce and dst_we are both high.
// All outputs are registered.
module sobel_core
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic                  src_ce,
  input  logic [DATA_WIDTH-1:0] src_q,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic                  dst_ce,
  output logic                  dst_we,
  output logic [DATA_WIDTH-1:0] dst_d,
  output state_e                state_dbg
);

  localparam logic [ADDR_WIDTH-1:0] X_MAX = ADDR_WIDTH'(IMG_W - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_MAX = ADDR_WIDTH'(IMG_H - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW1  = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] ROW2  = ADDR_WIDTH'(2 * IMG_W);
  localparam logic [3:0]            K_LAST = 4'(NUM_TAPS - 1);

  state_e                             state_q;
  logic [3:0]                         k_q, k_d;
  logic [ADDR_WIDTH-1:0]              x_q, y_q, x_d, y_d;
  logic [ADDR_WIDTH-1:0]              pix_addr_q;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] taps_q;
  logic                               busy_q, done_q, src_ce_q, dst_ce_q, dst_we_q;
  logic [ADDR_WIDTH-1:0]              src_addr_q, dst_addr_q, tap_addr_d;
  logic [DATA_WIDTH-1:0]              dst_d_q, kern_pix;
  logic [ADDR_WIDTH-1:0]              row_off;
  logic [3:0]                         col_off;
  logic                               is_border, is_last;

  sobel_kernel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_kernel (
    .taps_i(taps_q),
    .pix_o (kern_pix)
  );

  always_comb begin
    is_border = (x_q == '0) || (x_q == X_MAX) || (y_q == '0) || (y_q == Y_MAX);
    is_last   = (x_q == X_MAX) && (y_q == Y_MAX);
    if (x_q == X_MAX) begin
      x_d = '0;
      y_d = y_q + 1'b1;
    end else begin
      x_d = x_q + 1'b1;
      y_d = y_q;
    end
  end

  // Address of the next tap to issue: tap 0 when leaving SCAN, otherwise
  // the one after the tap currently in flight. The neighbourhood origin
  // (x-1, y-1) sits one row and one column before the centre pixel;
  // interior pixels never underflow this subtraction.
  always_comb begin
    k_d = (state_q == ST_SCAN) ? 4'd0 : k_q + 4'd1;
    if (k_d >= 4'd6) begin
      row_off = ROW2;
      col_off = k_d - 4'd6;
    end else if (k_d >= 4'd3) begin
      row_off = ROW1;
      col_off = k_d - 4'd3;
    end else begin
      row_off = '0;
      col_off = k_d;
    end
    tap_addr_d = pix_addr_q - ROW1 - ADDR_WIDTH'(1) + row_off + ADDR_WIDTH'(col_off);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pix_addr_q <= '0;
      taps_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_ce_q   <= 1'b0;
      src_addr_q <= '0;
      dst_ce_q   <= 1'b0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_d_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SCAN;
            busy_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (is_border) begin
            state_q    <= ST_WR;
            dst_ce_q   <= 1'b1;
            dst_we_q   <= 1'b1;
            dst_addr_q <= pix_addr_q;
            dst_d_q    <= '0;
          end else begin
            state_q    <= ST_RD;
            k_q        <= k_d;
            src_ce_q   <= 1'b1;
            src_addr_q <= tap_addr_d;
          end
        end
        ST_RD: begin
          // Data for tap k-1 is on src_q while tap k is being issued.
          if (k_q != 4'd0) begin
            taps_q[k_q - 4'd1] <= src_q;
          end
          if (k_q == K_LAST) begin
            state_q  <= ST_LAST;
            src_ce_q <= 1'b0;
          end else begin
            k_q        <= k_d;
            src_addr_q <= tap_addr_d;
          end
        end
        ST_LAST: begin
          taps_q[NUM_TAPS-1] <= src_q;
          state_q            <= ST_CALC;
        end
        ST_CALC: begin
          state_q    <= ST_WR;
          dst_d_q    <= kern_pix;
          dst_ce_q   <= 1'b1;
          dst_we_q   <= 1'b1;
          dst_addr_q <= pix_addr_q;
        end
        ST_WR: begin
          dst_ce_q <= 1'b0;
          dst_we_q <= 1'b0;
          if (is_last) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            x_q        <= '0;
            y_q        <= '0;
            pix_addr_q <= '0;
          end else begin
            state_q    <= ST_SCAN;
            x_q        <= x_d;
            y_q        <= y_d;
            pix_addr_q <= pix_addr_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign src_ce    = src_ce_q;
  assign src_addr  = src_addr_q;
  assign dst_ce    = dst_ce_q;
  assign dst_we    = dst_we_q;
  assign dst_addr  = dst_addr_q;
  assign dst_d     = dst_d_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sobel_core.sv
// tb_sobel_core
// Frame-level bench for sobel_core on a 4x4 image. A behavioural model
// computes every output pixel and every expected source read address from
// a 2-D image array; monitors pop and compare on each DUT read and write.
module tb_sobel_core;
  import sobel_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NI   = (W - 2) * (H - 2);
  localparam int NB   = NPIX - NI;
  localparam int FRAME_CYC = 2 * NB + 13 * NI + 1;
  localparam int BUDGET    = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, src_ce, dst_ce, dst_we;
  logic [AW-1:0] src_addr, dst_addr;
  logic [DW-1:0] src_q, dst_d;
  state_e        state_dbg;

  int            img [H][W];
  logic [DW-1:0] src_mem [NPIX];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    rd_q[$];

  sobel_core #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .src_addr (src_addr),
    .src_ce   (src_ce),
    .src_q    (src_q),
    .dst_addr (dst_addr),
    .dst_ce   (dst_ce),
    .dst_we   (dst_we),
    .dst_d    (dst_d),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / source RAM ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (src_ce) src_q <= src_mem[int'(src_addr) % NPIX];
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_pix(input int x, input int y);
    int gx, gy, m;
    if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return 0;
    gx = (img[y-1][x+1] + 2 * img[y][x+1] + img[y+1][x+1])
       - (img[y-1][x-1] + 2 * img[y][x-1] + img[y+1][x-1]);
    gy = (img[y+1][x-1] + 2 * img[y+1][x] + img[y+1][x+1])
       - (img[y-1][x-1] + 2 * img[y-1][x] + img[y-1][x+1]);
    m = iabs(gx) + iabs(gy);
    return (m > 255) ? 255 : m;
  endfunction

  // pat: 0 constant 100, 1 ramp 10*x, 2 step at x=2, 3 ramp 10*y, 4 random
  task automatic load_image(input int pat);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (pat)
          0:       img[y][x] = 100;
          1:       img[y][x] = 10 * x;
          2:       img[y][x] = (x < 2) ? 0 : 255;
          3:       img[y][x] = 10 * y;
          default: img[y][x] = int'($urandom_range(0, 255));
        endcase
        src_mem[y * W + x] = DW'(img[y][x]);
      end
    end
  endtask

  task automatic push_expected();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        exp_q.push_back({AW'(y * W + x), DW'(ref_pix(x, y))});
        if (!(x == 0 || y == 0 || x == W - 1 || y == H - 1)) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              rd_q.push_back(AW'((y + r - 1) * W + (x + c - 1)));
        end
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    ra;
    if (!reset) begin
      if (done) done_cnt++;
      if (dst_ce || dst_we) begin
        wr_cnt++;
        check("dst_we_eq_ce", {31'd0, dst_we}, {31'd0, dst_ce});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0d, none expected", dst_addr, dst_d);
        end else begin
          e = exp_q.pop_front();
          check("dst_addr", 32'(dst_addr), 32'(e[AW+DW-1:DW]));
          check("dst_d", 32'(dst_d), 32'(e[DW-1:0]));
        end
      end
      if (src_ce) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: addr %0d, none expected", src_addr);
        end else begin
          ra = rd_q.pop_front();
          check("src_addr", 32'(src_addr), 32'(ra));
        end
      end
    end
  end

  // ---------------- frame driver ----------------
  task automatic run_frame(input int pat, input bit double_start);
    int cyc, d0, w0;
    load_image(pat);
    push_expected();
    d0 = done_cnt;
    w0 = wr_cnt;
    @(negedge clk);
    check("busy_before_start", {31'd0, busy}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_rise", {31'd0, busy}, 32'd1);
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      start = (double_start && (cyc == 20 || cyc == 50)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("done_cycle", 32'(cyc), 32'(FRAME_CYC));
    @(negedge clk);
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    repeat (4) @(negedge clk);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("write_count", 32'(wr_cnt - w0), 32'(NPIX));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    exp_q.delete();
    rd_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_src_ce"}, {31'd0, src_ce}, 32'd0);
    check({tag, "_src_addr"}, 32'(src_addr), 32'd0);
    check({tag, "_dst_ce"}, {31'd0, dst_ce}, 32'd0);
    check({tag, "_dst_we"}, {31'd0, dst_we}, 32'd0);
    check({tag, "_dst_addr"}, 32'(dst_addr), 32'd0);
    check({tag, "_dst_d"}, 32'(dst_d), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    run_frame(0, 1'b0);   // constant image
    run_frame(1, 1'b0);   // horizontal ramp
    run_frame(2, 1'b0);   // step edge, saturating
    run_frame(3, 1'b0);   // vertical ramp
    run_frame(4, 1'b1);   // random, extra start pulses while busy
    run_frame(4, 1'b0);   // random

    // Abort a frame during the first interior pixel's tap reads.
    load_image(4);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (state_dbg != ST_RD && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_rd", 32'(state_dbg), 32'(ST_RD));
    #1 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    rd_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    run_frame(4, 1'b0);   // full frame after abort restarts at (0,0)

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_core.md
# sobel_core

Sobel gradient engine that sits directly downstream of the image frame buffer, a dual-port block RAM. It reads an 8-bit greyscale frame through one read port, computes the clamped gradient magnitude |Gx|+|Gy| for every pixel, and writes the result frame into a second block RAM through a write port. Operation is start/done driven and processes one pixel at a time in raster order.

## Interface
- DATA_WIDTH, 8, pixel width in bits.
- ADDR_WIDTH, 16, RAM address width. IMG_W*IMG_H must be ≤ 2^ADDR_WIDTH.
- IMG_W, 256, frame width in pixels. Must be ≥ 3.
- IMG_H, 256, frame height in pixels. Must be ≥ 3.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; returns all state to reset values.
- start  in  1  one-cycle request to process a frame; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the last output pixel has been written.
- src_addr  out  ADDR_WIDTH  source frame read address.
- src_ce  out  1  source read enable; the source write enable is tied 0 externally.
- src_q  in  DATA_WIDTH  source read data, valid one cycle after src_ce.
- dst_addr  out  ADDR_WIDTH  result frame write address.
- dst_ce  out  1  result chip enable.
- dst_we  out  1  result write enable; asserted together with dst_ce.
- dst_d  out  DATA_WIDTH  result pixel.

## Operation
- Pixel (x,y) maps to address y*IMG_W + x. Scan order is x fastest, from (0,0) to (IMG_W-1, IMG_H-1).
- Border pixels (x=0, x=IMG_W-1, y=0, y=IMG_H-1) are written as 0 with no source reads.
- Interior pixel taps are p[r*3+c] at (x+c-1, y+r-1), for r,c in 0..2, read in order k=0..8.
- Gx = (p2 + 2·p5 + p8) − (p0 + 2·p3 + p6).
- Gy = (p6 + 2·p7 + p8) − (p0 + 2·p1 + p2).
- Gx and Gy are signed 11-bit values, range ±1020.
- mag = |Gx| + |Gy| is unsigned 12-bit. dst_d = mag > 255 ? 255 : mag[7:0].
- FSM states and transitions:
  - IDLE: start → SCAN.
  - SCAN: border pixel → WR; interior pixel → RD with k=0.
  - RD: issues tap k for 9 cycles, k=0..8. k=8 → LAST.
  - LAST: captures tap 8 → CALC.
  - CALC: registers mag → WR.
  - WR: one-cycle write, then advances the pixel. Last pixel → DONE, otherwise → SCAN.
  - DONE: done=1 → IDLE.
- Each tap is captured from src_q in the cycle after its address was issued.
- start while not in IDLE is ignored; it is not queued.

## Timing
- Reset values: busy=0, done=0, src_ce=0, src_addr=0, dst_ce=0, dst_we=0, dst_addr=0, dst_d=0. FSM returns to IDLE and the x,y counters go to 0.
- Reset mid-frame aborts immediately. The partially written destination is left as is; the next start restarts at (0,0).
- Cycle count from entering SCAN to the end of WR:
  - border pixel: 2 cycles (SCAN, WR).
  - interior pixel: 13 cycles (SCAN, 9×RD, LAST, CALC, WR).
- Frame cycles = 2·B + 13·I + 1 (DONE), where I=(IMG_W−2)(IMG_H−2) and B=IMG_W·IMG_H−I.
- busy rises the cycle after start and falls the cycle after DONE.
- src_ce is high only in RD; dst_ce and dst_we are high only in WR.
- Source and destination are distinct RAMs, so there is no read/write hazard.

## Structure
- Shared package contents:
  - FSM state encoding: IDLE, SCAN, RD, LAST, CALC, WR, DONE.
  - Kernel width constants: GRAD_W=11, MAG_W=12.
  - Saturation limit: 255.
- Sub-module sobel_kernel: combinational. Takes nine taps and produces the clamped magnitude; it is registered in CALC by the parent.
- The tap register file, x/y counters, address generation and FSM live in sobel_core.

## Test plan
- Constant image of 100s, IMG_W=IMG_H=4 → all 16 outputs 0; done pulses exactly once, at frame cycle 2·12+13·4+1=77.
- Ramp image, pixel = 10·x, 4×4 → interior outputs (1,1),(2,1),(1,2),(2,2) = 80; every border output = 0.
- Step image, x<2 → 0 else 255 → interior magnitude 1020 is clamped, so dst_d = 255.
- start pulsed again while busy=1 → ignored: exactly 16 writes and one done pulse.
- reset asserted during RD of pixel (1,1) → all outputs at reset values within the same cycle, state IDLE. A following start yields a correct full frame.
- Source RAM model with 1-cycle read latency → every tap matches the 3×3 neighbourhood, checked against a scoreboard of 9·I read addresses.
